mem_pipe_ctrl: RTL
==================

MEM_PIPE_CTRL -- requirements
Module: mem_pipe_ctrl

Interface
REQ-001 SHALL have parameter LOCATIONS, default 16: number of words; any integer >= 2, not necessarily a power of 2.
REQ-002 SHALL have parameter LOCATION_SIZE, default 32: word width in bits; a multiple of 8.
REQ-003 SHALL have parameter RD_LATENCY, default 2: accept-to-response cycles, legal range 1..4.
REQ-004 SHALL define AW = $clog2(LOCATIONS), BW = LOCATION_SIZE/8, and DEPTH = RD_LATENCY+1 (response buffer entries).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request can be accepted this cycle.
REQ-009 op  in  1  1 = write, 0 = read.
REQ-010 addr  in  AW  word address.
REQ-011 data_in  in  LOCATION_SIZE  write data.
REQ-012 byte_en  in  BW  write byte lanes; bit i enables data_in[8i+7:8i].
REQ-013 rsp_valid  out  1  read response present.
REQ-014 rsp_ready  in  1  consumer takes the response.
REQ-015 data_out  out  LOCATION_SIZE  read data.
REQ-016 rsp_err  out  1  response is for an out-of-range address.

Function
REQ-017 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1; accepted requests SHALL be processed strictly in acceptance order.
REQ-018 SHALL perform an accepted write at its accept edge, updating only the byte lanes whose byte_en bit is 1; writes SHALL produce no response.
REQ-019 SHALL sample memory for an accepted read at its accept edge, so the read sees every earlier-accepted write, including one accepted on the immediately preceding edge.
REQ-020 SHALL make read data visible on rsp_valid/data_out exactly RD_LATENCY cycles after the accept edge when the response buffer is empty and rsp_ready=1.
REQ-021 SHALL carry read data through a RD_LATENCY-stage valid-tagged pipeline, then a DEPTH-entry FIFO; FIFO head drives rsp_valid/data_out/rsp_err.
REQ-022 SHALL hold rsp_valid, data_out and rsp_err stable while rsp_valid=1 and rsp_ready=0; the head SHALL pop on the edge where rsp_valid=1 and rsp_ready=1.
REQ-023 SHALL track reads in flight: credits = reads in pipeline + FIFO occupancy.
REQ-024 SHALL drive req_ready=1 when credits < DEPTH, else req_ready=0; req_ready SHALL depend only on registered state, not on req_valid or rsp_ready.
REQ-025 SHALL never drop or overwrite a response; the FIFO SHALL never overflow.
REQ-026 SHALL process simultaneous pop and push correctly; occupancy is then unchanged.
REQ-027 SHALL keep req_ready=1 for writes even when credits are exhausted? No: req_ready is op-independent, and a write is accepted only when req_ready=1.
REQ-028 SHALL treat a write with addr >= LOCATIONS as discarded with no memory change.
REQ-029 SHALL return, for a read with addr >= LOCATIONS, data_out=0 with rsp_err=1, at normal latency; in-range reads SHALL set rsp_err=0.
REQ-030 SHALL wrap FIFO read/write pointers modulo DEPTH; occupancy SHALL be tracked in $clog2(DEPTH+1) bits to distinguish full from empty.
REQ-031 SHALL ignore op, addr, data_in and byte_en when no request is accepted.

Reset
REQ-032 SHALL, on reset=0, immediately and asynchronously clear all memory words to 0, empty the pipeline and FIFO, and drive rsp_valid=0, data_out=0, rsp_err=0, req_ready=0.
REQ-033 SHALL discard reads in flight on reset mid-operation; no response for them SHALL ever appear.
REQ-034 SHALL drive req_ready=1 from the first rising edge after reset deasserts.

Verification
REQ-035 Write 0xDEADBEEF to addr 3 with byte_en=4'hF, then read addr 3 on the next cycle with RD_LATENCY=2 and rsp_ready=1 -> rsp_valid=1 with data_out=0xDEADBEEF and rsp_err=0 exactly 2 cycles after the read accept edge.
REQ-036 Write 0x11223344 to addr 5, then write 0xAABBCCDD to addr 5 with byte_en=4'b0101, then read addr 5 -> data_out=0x11BB33DD.
REQ-037 Hold rsp_ready=0 and issue back-to-back reads to addrs 0..7 with RD_LATENCY=2 -> exactly 3 accepted, then req_ready=0; releasing rsp_ready returns the 3 responses in order with no loss, after which acceptance resumes.
REQ-038 With LOCATIONS=12, write to addr 13, then read addr 13 and addr 0 -> first response data_out=0 with rsp_err=1; second response rsp_err=0; memory unchanged.
REQ-039 Issue 2 reads, then assert reset before either responds; release reset -> no stale rsp_valid appears, all words read 0, and req_ready=1 one edge after release.
REQ-040 Toggle rsp_ready randomly with continuous random requests against a reference model -> responses match in order, with no overflow and no stall deadlock.

Source files
------------

// File: rtl/mem_pipe_ctrl.sv
// Byte-enabled word memory with fixed-latency reads, a response FIFO sized so that
// every accepted read always has a slot, and credit-based request back-pressure.
module mem_pipe_ctrl #(
  parameter int LOCATIONS     = 16,
  parameter int LOCATION_SIZE = 32,
  parameter int RD_LATENCY    = 2,
  localparam int AW           = $clog2(LOCATIONS),
  localparam int BW           = LOCATION_SIZE / 8,
  localparam int DEPTH        = RD_LATENCY + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     op,
  input  logic [AW-1:0]            addr,
  input  logic [LOCATION_SIZE-1:0] data_in,
  input  logic [BW-1:0]            byte_en,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [LOCATION_SIZE-1:0] data_out,
  output logic                     rsp_err
);

  // Handshakes: a request transfers on a rising edge with req_valid & req_ready;
  // a response transfers on a rising edge with rsp_valid & rsp_ready. Neither
  // ready depends combinationally on the matching valid.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [LOCATION_SIZE-1:0] mem [LOCATIONS];

  logic                     accept;
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     in_range;
  logic [LOCATION_SIZE-1:0] rd_word;

  logic                     pipe_v [RD_LATENCY];
  logic [LOCATION_SIZE-1:0] pipe_d [RD_LATENCY];
  logic                     pipe_e [RD_LATENCY];

  logic [LOCATION_SIZE-1:0] fifo_d [DEPTH];
  logic                     fifo_e [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            count_q;
  logic [CW-1:0]            credits_q;
  logic                     started_q;
  logic                     push;
  logic                     pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_range  = (32'(addr) < LOCATIONS);
  assign req_ready = started_q && (credits_q < CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign wr_acc    = accept && op;
  assign rd_acc    = accept && !op;
  assign rd_word   = in_range ? mem[addr] : '0;

  assign push      = pipe_v[RD_LATENCY-1];
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign data_out  = rsp_valid ? fifo_d[rd_ptr] : '0;
  assign rsp_err   = rsp_valid && fifo_e[rd_ptr];

  // Out-of-range writes are dropped silently; only enabled lanes change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LOCATIONS; i++) mem[i] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < BW; b++) begin
        if (byte_en[b]) mem[addr][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_v[s] <= 1'b0;
        pipe_d[s] <= '0;
        pipe_e[s] <= 1'b0;
      end
    end else begin
      pipe_v[0] <= rd_acc;
      pipe_d[0] <= rd_word;
      pipe_e[0] <= !in_range;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_d[s] <= pipe_d[s-1];
        pipe_e[s] <= pipe_e[s-1];
      end
    end
  end

  // Credits cover the pipeline too, so a push always finds a free FIFO entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_d[i] <= '0;
        fifo_e[i] <= 1'b0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      credits_q <= '0;
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
      if (push) begin
        fifo_d[wr_ptr] <= pipe_d[RD_LATENCY-1];
        fifo_e[wr_ptr] <= pipe_e[RD_LATENCY-1];
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      case ({rd_acc, pop})
        2'b10:   credits_q <= credits_q + CW'(1);
        2'b01:   credits_q <= credits_q - CW'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

endmodule
